// File: rtl/buzzer_sequencer_if.sv
// rtl/buzzer_sequencer_if.sv - request/response bundle between keypad decoder and buzzer sequencer
// The mute line exists only when BUZZ_MUTE_EN is defined.
interface buzzer_sequencer_if;
   logic       req_click;
   logic       req_pass;
   logic       req_fail;
`ifdef BUZZ_MUTE_EN
   logic       mute;
`endif
   logic       buzzer;
   logic       busy;
   logic [1:0] active_id;
   logic       done;

`ifdef BUZZ_MUTE_EN
   modport master (
      output req_click, req_pass, req_fail, mute,
      input  buzzer, busy, active_id, done
   );
   modport slave (
      input  req_click, req_pass, req_fail, mute,
      output buzzer, busy, active_id, done
   );
`else
   modport master (
      output req_click, req_pass, req_fail,
      input  buzzer, busy, active_id, done
   );
   modport slave (
      input  req_click, req_pass, req_fail,
      output buzzer, busy, active_id, done
   );
`endif
endinterface

// File: rtl/buzzer_sequencer.sv
// rtl/buzzer_sequencer.sv - arbitrates click/pass/fail requests and plays the winning tone pattern
// Optional BUZZ_MUTE_EN adds a mute input that silences the buzzer without disturbing sequencing.
module buzzer_sequencer #(
   parameter int unsigned CLICK_HALF = 50000,
   parameter int unsigned CLICK_LEN  = 10000000,
   parameter int unsigned PASS_HALF  = 25000,
   parameter int unsigned PASS_LEN   = 30000000,
   parameter int unsigned FAIL_HALF  = 100000,
   parameter int unsigned FAIL_LEN   = 15000000,
   parameter int unsigned GAP_START  = 5000000,
   parameter int unsigned GAP_END    = 10000000
) (
   input  logic              clk,
   input  logic              rst,
   buzzer_sequencer_if.slave bus
);

   // Encoding doubles as priority order and as the active_id value.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLICK = 2'd1,
      S_PASS  = 2'd2,
      S_FAIL  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   state_t      w_req_state;
   logic [31:0] r_half_cnt;
   logic [31:0] w_half_next;
   logic [31:0] r_dur_cnt;
   logic [31:0] w_dur_next;
   logic        r_tone_q;
   logic        w_tone_next;
   logic        r_buzzer;
   logic        w_buzzer_next;
   logic        r_busy;
   logic [1:0]  r_active_id;
   logic        r_done;
   logic        w_done_next;
   logic        w_accept;
   logic        w_gap;
   logic        w_mute;
   logic [31:0] w_half_lim;
   logic [31:0] w_len_lim;

`ifdef BUZZ_MUTE_EN
   assign w_mute = bus.mute;
`else
   assign w_mute = 1'b0;
`endif

   always_comb begin
      w_req_state = S_IDLE;
      if (bus.req_fail)
         w_req_state = S_FAIL;
      else if (bus.req_pass)
         w_req_state = S_PASS;
      else if (bus.req_click)
         w_req_state = S_CLICK;
   end

   // Equal priority restarts, higher preempts, lower is dropped.
   assign w_accept = (w_req_state != S_IDLE) && (w_req_state >= r_state);

   always_comb begin
      w_half_lim = 32'd0;
      w_len_lim  = 32'd0;
      case (r_state)
         S_CLICK: begin
            w_half_lim = CLICK_HALF - 1;
            w_len_lim  = CLICK_LEN - 1;
         end
         S_PASS: begin
            w_half_lim = PASS_HALF - 1;
            w_len_lim  = PASS_LEN - 1;
         end
         S_FAIL: begin
            w_half_lim = FAIL_HALF - 1;
            w_len_lim  = FAIL_LEN - 1;
         end
         default: begin
            w_half_lim = 32'd0;
            w_len_lim  = 32'd0;
         end
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_half_next  = r_half_cnt;
      w_dur_next   = r_dur_cnt;
      w_tone_next  = r_tone_q;
      w_done_next  = 1'b0;
      if (w_accept) begin
         w_state_next = w_req_state;
         w_half_next  = 32'd0;
         w_dur_next   = 32'd0;
         w_tone_next  = 1'b1;
      end else if (r_state != S_IDLE) begin
         if (r_dur_cnt == w_len_lim) begin
            w_state_next = S_IDLE;
            w_half_next  = 32'd0;
            w_dur_next   = 32'd0;
            w_tone_next  = 1'b0;
            w_done_next  = 1'b1;
         end else begin
            w_dur_next = r_dur_cnt + 32'd1;
            if (r_half_cnt == w_half_lim) begin
               w_half_next = 32'd0;
               w_tone_next = ~r_tone_q;
            end else begin
               w_half_next = r_half_cnt + 32'd1;
            end
         end
      end
   end

   // Gap is judged on the count the registered buzzer will be shown alongside.
   assign w_gap = (w_state_next == S_FAIL) && (w_dur_next >= GAP_START) && (w_dur_next < GAP_END);
   assign w_buzzer_next = w_tone_next & ~w_gap & ~w_mute;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_half_cnt  <= 32'd0;
         r_dur_cnt   <= 32'd0;
         r_tone_q    <= 1'b0;
         r_buzzer    <= 1'b0;
         r_busy      <= 1'b0;
         r_active_id <= 2'd0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_half_cnt  <= w_half_next;
         r_dur_cnt   <= w_dur_next;
         r_tone_q    <= w_tone_next;
         r_buzzer    <= w_buzzer_next;
         r_busy      <= (w_state_next != S_IDLE);
         r_active_id <= w_state_next;
         r_done      <= w_done_next;
      end
   end

   assign bus.buzzer    = r_buzzer;
   assign bus.busy      = r_busy;
   assign bus.active_id = r_active_id;
   assign bus.done      = r_done;

endmodule
